// File: rtl/conv_layer_engine_if.sv
// Pixel stream, weight ROM and output feature bus of conv_layer_engine.
// The engine connects to the slave modport; the feeding/consuming side uses master.
interface conv_layer_engine_if #(
    parameter int WIDTH  = 16,
    parameter int DSP_NO = 64,
    parameter int AW     = 12
);
    logic                     pix_valid_i;
    logic                     pix_ready_o;
    logic [WIDTH-1:0]         pix_i;
    logic [AW-1:0]            ker_addr_o;
    logic [DSP_NO*WIDTH-1:0]  ker_i;
    logic                     ofm_valid_o;
    logic [DSP_NO*WIDTH-1:0]  ofm_o;

    modport master (
        output pix_valid_i, pix_i, ker_i,
        input  pix_ready_o, ker_addr_o, ofm_valid_o, ofm_o
    );

    modport slave (
        input  pix_valid_i, pix_i, ker_i,
        output pix_ready_o, ker_addr_o, ofm_valid_o, ofm_o
    );
endinterface

// File: rtl/conv_layer_engine.sv
// Convolution layer engine: pixel-serial MAC over KERNEL_DIM^2*CHIN terms, then bias,
// requantisation and saturation for DSP_NO channels. CONV_LAYER_ENGINE_RELU_EN enables ReLU.
module conv_layer_engine #(
    parameter int WIDTH      = 16,
    parameter int FRAC       = 14,
    parameter int DSP_NO     = 64,
    parameter int CHIN       = 256,
    parameter int KERNEL_DIM = 3,
    parameter int WOUT       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic [DSP_NO*2*WIDTH-1:0]  bias_i,
    input  logic                       ram_feedback_i,
    output logic                       busy_o,
    output logic                       finish_o,
    conv_layer_engine_if.slave         bus
);
    localparam int T     = KERNEL_DIM * KERNEL_DIM * CHIN;
    localparam int AW    = $clog2(T);
    localparam int ACC_W = 2 * WIDTH + AW;
    localparam int SW    = ACC_W + 1;
    localparam int NPIX  = WOUT * WOUT;
    localparam int PW    = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic signed [SW-1:0] QMAX = SW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] QMIN = -QMAX - SW'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     term_cnt;
    logic [PW-1:0]     pix_cnt;
    logic              xfer, last_term, last_pix;
    logic              pix_ready, busy, finish;

    logic                       v0, first0, last0, end0;
    logic signed [WIDTH-1:0]    pix0;
    logic                       v1, first1, last1, end1;
    logic signed [WIDTH-1:0]    pix1;
    logic [DSP_NO*WIDTH-1:0]    ker1;
    logic                       v2, first2, last2, end2;
    logic signed [2*WIDTH-1:0]  prod [DSP_NO];
    logic                       v3, last3, end3;
    logic signed [ACC_W-1:0]    acc [DSP_NO];
    logic                       ofm_valid, ofm_end;
    logic [DSP_NO*WIDTH-1:0]    ofm, ofm_nxt;

    assign xfer      = bus.pix_valid_i && (state == RUN);
    assign last_term = (term_cnt == AW'(T - 1));
    assign last_pix  = (pix_cnt == PW'(NPIX - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pix_ready = 1'b0;
        busy      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: if (start_i) state_nxt = RUN;
            RUN: begin
                pix_ready = 1'b1;
                busy      = 1'b1;
                if (xfer && last_term && last_pix) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                // Earlier pixels may still pulse while draining; only the tagged last one ends the layer.
                if (ofm_valid && ofm_end) state_nxt = DONE;
            end
            DONE: begin
                finish = 1'b1;
                if (ram_feedback_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            term_cnt <= '0;
            pix_cnt  <= '0;
        end else if (state == IDLE && start_i) begin
            term_cnt <= '0;
            pix_cnt  <= '0;
        end else if (xfer) begin
            if (last_term) begin
                term_cnt <= '0;
                pix_cnt  <= pix_cnt + PW'(1);
            end else begin
                term_cnt <= term_cnt + AW'(1);
            end
        end
    end

    function automatic logic [WIDTH-1:0] requant(input logic signed [ACC_W-1:0] a,
                                                 input logic signed [2*WIDTH-1:0] b);
        logic signed [SW-1:0] s;
        logic signed [SW-1:0] q;
        logic [WIDTH-1:0]     r;
        s = SW'(a) + SW'(b);
        q = s >>> FRAC;
        if (q > QMAX)      r = {1'b0, {(WIDTH-1){1'b1}}};
        else if (q < QMIN) r = {1'b1, {(WIDTH-1){1'b0}}};
        else               r = q[WIDTH-1:0];
`ifdef CONV_LAYER_ENGINE_RELU_EN
        if (r[WIDTH-1]) r = '0;
`endif
        return r;
    endfunction

    always_comb begin
        ofm_nxt = '0;
        for (int unsigned i = 0; i < DSP_NO; i++) begin
            ofm_nxt[i*WIDTH +: WIDTH] = requant(acc[i], $signed(bias_i[i*2*WIDTH +: 2*WIDTH]));
        end
    end

    // ROM data answers the address of the accepting cycle one clock later, so it joins
    // the pixel in S1 rather than at the transfer edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            v0        <= 1'b0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            ofm_valid <= 1'b0;
            ofm_end   <= 1'b0;
            ofm       <= '0;
        end else begin
            v0     <= xfer;
            first0 <= (term_cnt == '0);
            last0  <= last_term;
            end0   <= last_term && last_pix;
            pix0   <= bus.pix_i;

            v1     <= v0;
            first1 <= first0;
            last1  <= last0;
            end1   <= end0;
            pix1   <= pix0;
            ker1   <= bus.ker_i;

            v2     <= v1;
            first2 <= first1;
            last2  <= last1;
            end2   <= end1;
            for (int unsigned i = 0; i < DSP_NO; i++) begin
                prod[i] <= (2*WIDTH)'(pix1) * (2*WIDTH)'($signed(ker1[i*WIDTH +: WIDTH]));
            end

            v3    <= v2;
            last3 <= last2;
            end3  <= end2;
            if (v2) begin
                for (int unsigned i = 0; i < DSP_NO; i++) begin
                    if (first2) acc[i] <= ACC_W'(prod[i]);
                    else        acc[i] <= acc[i] + ACC_W'(prod[i]);
                end
            end

            ofm_valid <= v3 && last3;
            ofm_end   <= v3 && last3 && end3;
            if (v3 && last3) ofm <= ofm_nxt;
        end
    end

    assign bus.pix_ready_o = pix_ready;
    assign bus.ker_addr_o  = term_cnt;
    assign bus.ofm_valid_o = ofm_valid;
    assign bus.ofm_o       = ofm;
    assign busy_o          = busy;
    assign finish_o        = finish;
endmodule

// File: tb/tb_conv_layer_engine.sv
// Directed bench for conv_layer_engine: two hand-computed layers, gaps, rerun and mid-run reset.
module tb_conv_layer_engine;
    localparam int WIDTH      = 16;
    localparam int FRAC       = 14;
    localparam int DSP_NO     = 2;
    localparam int CHIN       = 2;
    localparam int KERNEL_DIM = 1;
    localparam int WOUT       = 2;
    localparam int T          = 2;
    localparam int AW         = 1;
    localparam int NTERM      = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic ram_fb = 1'b0;
    logic busy, finish;
    logic [DSP_NO*2*WIDTH-1:0] bias = '0;
    logic [DSP_NO*WIDTH-1:0]   rom [T];

    conv_layer_engine_if #(.WIDTH(WIDTH), .DSP_NO(DSP_NO), .AW(AW)) bus ();

    conv_layer_engine #(
        .WIDTH(WIDTH), .FRAC(FRAC), .DSP_NO(DSP_NO),
        .CHIN(CHIN), .KERNEL_DIM(KERNEL_DIM), .WOUT(WOUT)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start), .bias_i(bias),
        .ram_feedback_i(ram_fb), .busy_o(busy), .finish_o(finish), .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.ker_i <= rom[bus.ker_addr_o];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] got[$];
    int          got_cyc[$];
    int          acc_cyc[$];
    always @(negedge clk) begin
        if (bus.ofm_valid_o === 1'b1) begin
            got.push_back(bus.ofm_o);
            got_cyc.push_back(cyc);
        end
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    logic [15:0] pix_tab [2][NTERM];
    logic [31:0] rom_tab [2][T];
    logic [63:0] bias_tab[2];
    logic [31:0] exp_tab [2][4];

    function automatic logic [31:0] relu2(input logic [31:0] v);
        logic [31:0] r;
        r = v;
`ifdef CONV_LAYER_ENGINE_RELU_EN
        if (r[15]) r[15:0]  = '0;
        if (r[31]) r[31:16] = '0;
`endif
        return r;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_ready"},    32'(bus.pix_ready_o), 32'd0);
        check_val({tag, "_busy"},     32'(busy),            32'd0);
        check_val({tag, "_finish"},   32'(finish),          32'd0);
        check_val({tag, "_ofmvalid"}, 32'(bus.ofm_valid_o), 32'd0);
        check_val({tag, "_kaddr"},    32'(bus.ker_addr_o),  32'd0);
    endtask

    task automatic run_layer(input int l, input bit gaps);
        int gap;
        int w;
        int fcyc;
        rom[0] = rom_tab[l][0];
        rom[1] = rom_tab[l][1];
        bias   = bias_tab[l];
        got.delete();
        got_cyc.delete();
        acc_cyc.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_val("run_ready", 32'(bus.pix_ready_o), 32'd1);
        check_val("run_busy",  32'(busy),            32'd1);
        for (int k = 0; k < NTERM; k++) begin
            gap = (gaps && k != 0 && k != 4 && k != 5) ? int'($urandom_range(3)) : 0;
            repeat (gap) begin @(posedge clk); #1; end
            bus.pix_valid_i = 1'b1;
            bus.pix_i       = pix_tab[l][k];
            check_val($sformatf("kaddr_l%0d_t%0d", l, k), 32'(bus.ker_addr_o), 32'(k % T));
            @(posedge clk); #1;
            acc_cyc.push_back(cyc);
            bus.pix_valid_i = 1'b0;
        end
        check_val("drain_ready", 32'(bus.pix_ready_o), 32'd0);
        check_val("drain_busy",  32'(busy),            32'd1);
        w = 0;
        while (finish !== 1'b1 && w < 30) begin
            @(negedge clk);
            w++;
        end
        fcyc = cyc;
        check_val("finish_seen", 32'(finish), 32'd1);
        check_val($sformatf("pulses_l%0d", l), 32'(got.size()), 32'd4);
        for (int p = 0; p < 4; p++) begin
            if (p < got.size()) begin
                check_val($sformatf("ofm_l%0d_p%0d", l, p), got[p], relu2(exp_tab[l][p]));
                check_val($sformatf("lat_l%0d_p%0d", l, p),
                          32'(got_cyc[p] - acc_cyc[2*p+1]), 32'd4);
            end
        end
        if (got.size() > 0)
            check_val("done_delay", 32'(fcyc - got_cyc[got.size()-1]), 32'd1);
        check_val("done_busy", 32'(busy), 32'd0);
        check_val("ofm_hold", bus.ofm_o, relu2(exp_tab[l][3]));
        repeat (2) @(negedge clk);
        check_val("finish_hold", 32'(finish), 32'd1);
        @(posedge clk); #1;
        ram_fb = 1'b1;
        @(posedge clk); #1;
        ram_fb = 1'b0;
        @(negedge clk);
        check_val("finish_drop", 32'(finish), 32'd0);
        check_idle_outputs("post_layer");
    endtask

    initial begin
        // layer 0: MAC, saturation both ways, negative result; bias 0
        pix_tab[0][0] = 16'h4000; pix_tab[0][1] = 16'h4000;
        pix_tab[0][2] = 16'h7FFF; pix_tab[0][3] = 16'h7FFF;
        pix_tab[0][4] = 16'h4000; pix_tab[0][5] = 16'h0000;
        pix_tab[0][6] = 16'hC000; pix_tab[0][7] = 16'h0000;
        rom_tab[0][0] = {16'h8000, 16'h4000};
        rom_tab[0][1] = {16'h8000, 16'h2000};
        bias_tab[0]   = '0;
        exp_tab[0][0] = {16'h8000, 16'h6000};
        exp_tab[0][1] = {16'h8000, 16'h7FFF};
        exp_tab[0][2] = {16'h8000, 16'h4000};
        exp_tab[0][3] = {16'h7FFF, 16'hC000};
        // layer 1: biases, truncation toward -inf, saturation with bias
        pix_tab[1][0] = 16'h0000; pix_tab[1][1] = 16'h0000;
        pix_tab[1][2] = 16'h7FFF; pix_tab[1][3] = 16'h7FFF;
        pix_tab[1][4] = 16'h0001; pix_tab[1][5] = 16'h0000;
        pix_tab[1][6] = 16'hFFFF; pix_tab[1][7] = 16'h0000;
        rom_tab[1][0] = {16'h8000, 16'h7FFF};
        rom_tab[1][1] = {16'h8000, 16'h7FFF};
        bias_tab[1]   = {32'hF000_0000, 32'h1000_0000};
        exp_tab[1][0] = {16'hC000, 16'h4000};
        exp_tab[1][1] = {16'h8000, 16'h7FFF};
        exp_tab[1][2] = {16'hBFFE, 16'h4001};
        exp_tab[1][3] = {16'hC002, 16'h3FFE};

        rom[0] = '0;
        rom[1] = '0;
        bus.pix_valid_i = 1'b0;
        bus.pix_i       = '0;

        repeat (3) @(posedge clk); #1;
        check_idle_outputs("reset");
        check_val("reset_ofm", bus.ofm_o, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("idle");

        rst = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        check_val("rst_beats_start", 32'(busy), 32'd0);

        run_layer(0, 1'b1);
        run_layer(1, 1'b0);

        rom[0] = rom_tab[0][0];
        rom[1] = rom_tab[0][1];
        bias   = bias_tab[0];
        got.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.pix_valid_i = 1'b1;
            bus.pix_i       = pix_tab[0][k];
            @(posedge clk); #1;
        end
        bus.pix_valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_val("midrst_pulses", 32'(got.size()), 32'd0);
        check_idle_outputs("midrst");
        check_val("midrst_ofm", bus.ofm_o, 32'd0);

        run_layer(0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/conv_layer_engine.md
# conv_layer_engine

Parametrised convolution layer engine: the generalised successor of the per-layer squeeze blocks. It accepts a pixel-serial input stream and fetches DSP_NO weights per term from an external synchronous ROM. Each output pixel is accumulated over KERNEL_DIM²·CHIN terms, then bias, requantisation, saturation and optional ReLU are applied. It sits between the line-buffer/feature RAM reader and the output feature RAM writer, one instance per layer.

## Interface
- WIDTH, 16: pixel/weight/output width, signed Q(WIDTH-FRAC).FRAC.
- FRAC, 14: fractional bits of pixels, weights and outputs.
- DSP_NO, 64: output channels computed in parallel.
- CHIN, 256: input channels.
- KERNEL_DIM, 3: kernel side.
- WOUT, 16: output map side; layer produces WOUT² output pixels.
- Derived T = KERNEL_DIM²·CHIN terms per output pixel.
- Derived AW = $clog2(T).
- Derived ACC_W = 2·WIDTH + AW.

- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  begin layer; sampled in IDLE only.
- pix_valid_i  in  1  pix_i valid.
- pix_ready_o  out  1  high in RUN; transfer = pix_valid_i & pix_ready_o.
- pix_i  in  WIDTH  signed input pixel, term order kernel-row, kernel-col, channel.
- ker_addr_o  out  AW  weight ROM address = current term index.
- ker_i  in  DSP_NO·WIDTH  ROM data, valid one clock after ker_addr_o; channel i at [i·WIDTH +: WIDTH].
- bias_i  in  DSP_NO·2·WIDTH  signed biases at product scale (2·FRAC fractional bits), static during a layer.
- ofm_valid_o  out  1  one-cycle pulse, ofm_o valid.
- ofm_o  out  DSP_NO·WIDTH  output pixel, all channels.
- busy_o  out  1  high in RUN or DRAIN.
- ram_feedback_i  in  1  downstream acknowledges layer completion.
- finish_o  out  1  layer done, awaiting ram_feedback_i.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on start_i. Term counter and pixel counter are cleared on entry.
  - RUN: each transfer advances the term counter. At T-1 it wraps to 0 and the pixel counter increments.
  - RUN → DRAIN on the transfer of term T-1 of pixel WOUT²-1.
  - DRAIN → DONE when the last ofm_valid_o pulse is issued.
  - DONE → IDLE on ram_feedback_i.
- Inputs ignored outside their states:
  - pix_valid_i outside RUN.
  - start_i outside IDLE.
  - ram_feedback_i outside DONE.
- Pipeline (per transfer):
  - S1: register pix_i, capture ker_i, first/last-term flags and valid.
  - S2: DSP_NO signed products, 2·WIDTH bits.
  - S3: accumulate. A first-term product loads the accumulator (no clear bubble); other terms add. Accumulation is sign-extended to ACC_W, with no overflow possible.
  - S4: on last-term valid, compute for each channel: s = acc + sign-extend(bias). Then q = s >>> FRAC (arithmetic shift, truncation). Then saturate q to [−2^(WIDTH-1), 2^(WIDTH-1)−1]. Register the result into ofm_o and pulse ofm_valid_o.
- Stage valid bits carry through every stage, so gaps in pix_valid_i are arbitrary. Gaps inside a pixel and between pixels do not corrupt sums.
- Back-to-back pixels (term T-1 followed directly by term 0) are fully supported at 1 term/clock.
- ofm_o holds its value between pulses.
- finish_o = (state == DONE).

## Timing
- Reset values:
  - state IDLE; counters 0.
  - All stage valids 0; ofm_o 0; ofm_valid_o 0.
  - pix_ready_o, busy_o and finish_o all 0.
  - ker_addr_o 0.
- ker_addr_o equals the term index of the transfer happening in the same cycle.
- Latency: ofm_valid_o is high in the cycle following the 4th rising edge after the edge that accepts the last term.
- DONE (finish_o high) begins one clock after the final ofm_valid_o pulse.
- finish_o drops the clock after ram_feedback_i is sampled high in DONE.
- Throughput: one output pixel per T accepted terms.
- rst mid-operation:
  - Returns to IDLE next edge.
  - All in-flight terms are discarded, with no ofm_valid_o pulse afterwards.
  - The accumulator contents are irrelevant, because the next first-term load overwrites them.
- Simultaneous start_i and rst: rst wins.

## Configuration
- CONV_LAYER_ENGINE_RELU_EN defined: after saturation, any negative result is replaced by 0.
- CONV_LAYER_ENGINE_RELU_EN undefined: the saturated signed result is output unchanged.

## Test plan
Bench parameters: WIDTH=16, FRAC=14, DSP_NO=2, CHIN=2, KERNEL_DIM=1, WOUT=2 (T=2, 4 pixels).
- Basic MAC: pix 0x4000,0x4000; ch0 weights 0x4000,0x2000; bias 0 → ch0 ofm 0x6000, ofm_valid_o exactly 4 clocks after second-term edge.
- Saturation: pix 0x7FFF ×2, weights 0x7FFF ×2 → 0x7FFF. Same with ch1 weights 0x8000, pix 0x7FFF → 0x8000 without RELU_EN, 0x0000 with.
- Negative and ReLU: pix 0x4000, weight 0xC000, second term 0 → 0xC000 without RELU_EN, 0x0000 with.
- Bias: pix 0, bias ch0 0x1000_0000 → ch0 0x4000; ch1 bias 0xF000_0000 → 0xC000 (0 with RELU_EN).
- Full layer with random 0–3 cycle gaps plus one back-to-back pixel:
  - Exactly 4 ofm_valid_o pulses, each matching the reference model.
  - pix_ready_o low after the 8th transfer.
  - finish_o high until ram_feedback_i, then IDLE; a second start_i reruns correctly.
- Reset mid-run: assert rst one clock after the 3rd transfer → no ofm_valid_o, all outputs at reset values. A subsequent layer gives correct results.
